// File: rtl/ova_capture.sv
// Camera capture front end for OV-series sensors: packs bus bytes into pixels,
// skips settle frames, checks frame geometry and drops frames on FIFO overflow.
module ova_capture #(
  parameter int DW_IN         = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACT         = 640,
  parameter int V_ACT         = 480,
  parameter int SKIP_FRAMES   = 10,
  parameter bit VS_POL        = 1'b1
) (
  input  logic                           i_pclk,
  input  logic                           rst_n,
  input  logic [DW_IN-1:0]               i_data,
  input  logic                           href,
  input  logic                           vsync,
  input  logic                           i_fifo_full,
  output logic [DW_IN*BYTES_PER_PIX-1:0] o_data,
  output logic                           o_data_vld,
  output logic                           o_sof,
  output logic                           o_eol,
  output logic                           o_eof,
  output logic                           o_frame_err,
  output logic [15:0]                    o_frame_cnt
);

  localparam int PW   = DW_IN * BYTES_PER_PIX;
  localparam int BC_W = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int PC_W = $clog2(H_ACT + 1);
  localparam int LC_W = $clog2(V_ACT + 1);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BYTES_PER_PIX - 1);
  localparam logic [PC_W-1:0] PC_MAX  = PC_W'(H_ACT);
  localparam logic [PC_W-1:0] PC_EOL  = PC_W'(H_ACT - 1);
  localparam logic [LC_W-1:0] LC_MAX  = LC_W'(V_ACT);
  localparam logic [8:0]      SKIP_N  = 9'(SKIP_FRAMES);

  typedef enum logic [1:0] {S_SKIP, S_WAIT, S_ACTIVE, S_DROP} state_t;

  state_t            state_q, state_d;
  logic [DW_IN-1:0]  data_p0;
  logic              href_p0, blank_p0;
  logic              href_q, blank_q;
  logic [7:0]        skip_cnt_q;
  logic [BC_W-1:0]   byte_cnt_q;
  logic [PC_W-1:0]   pix_cnt_q;
  logic [LC_W-1:0]   line_cnt_q, line_cnt_nx;
  logic              err_q, line_drop_q, first_pend_q;
  logic [PW-1:0]     acc_q, acc_nx;
  logic              vld_p1, sof_p1, eol_p1, eof_p1, ferr_p1;

  logic fs, fe, hrise, hfall, capture, ovf, beat, line_kill;
  logic pix_done, pix_emit, pix_over, hfall_act, err_set, frame_bad;
  logic fs_go, eof_d, ferr_d, cnt_inc;

  // stage p0: registered sensor pins
  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      href_p0  <= 1'b0;
      blank_p0 <= 1'b1;
      href_q   <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      href_p0  <= href;
      blank_p0 <= (vsync == VS_POL);
      href_q   <= href_p0;
      blank_q  <= blank_p0;
    end
  end

  always_ff @(posedge i_pclk) begin
    data_p0 <= i_data;
  end

  assign fs    = blank_q & ~blank_p0 & ~href_p0;
  assign fe    = ~blank_q & blank_p0;
  assign hrise = href_p0 & ~href_q;
  assign hfall = ~href_p0 & href_q;

  assign capture   = (state_q == S_ACTIVE);
  assign ovf       = capture & vld_p1 & i_fifo_full;
  assign beat      = capture & href_p0 & ~ovf;
  assign line_kill = line_drop_q | (capture & hrise & (line_cnt_q == LC_MAX));
  assign pix_done  = beat & (byte_cnt_q == BC_LAST);
  assign pix_over  = pix_done & ~line_kill & (pix_cnt_q == PC_MAX);
  assign pix_emit  = pix_done & ~line_kill & (pix_cnt_q != PC_MAX);
  assign hfall_act = capture & hfall;
  assign acc_nx    = (acc_q << DW_IN) | PW'(data_p0);

  assign err_set = ovf | pix_over
                 | (capture & hrise & (line_cnt_q == LC_MAX))
                 | (hfall_act & ((byte_cnt_q != '0) | (pix_cnt_q != PC_MAX)));

  assign line_cnt_nx = (hfall_act && (line_cnt_q != LC_MAX)) ? line_cnt_q + 1'b1 : line_cnt_q;
  assign frame_bad   = err_q | err_set | (line_cnt_nx != LC_MAX);

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= S_SKIP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fs_go   = 1'b0;
    eof_d   = 1'b0;
    ferr_d  = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      S_SKIP: begin
        if (SKIP_N == 9'd0)
          state_d = S_WAIT;
        else if (fe && ({1'b0, skip_cnt_q} + 9'd1 == SKIP_N))
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fs) begin
          state_d = S_ACTIVE;
          fs_go   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (fe) begin
          state_d = S_WAIT;
          eof_d   = 1'b1;
          ferr_d  = frame_bad;
          cnt_inc = ~frame_bad;
        end else if (ovf) begin
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (fe) begin
          state_d = S_WAIT;
          eof_d   = 1'b1;
          ferr_d  = 1'b1;
        end
      end
      default: state_d = S_SKIP;
    endcase
  end

  // stage p1: packing counters, frame bookkeeping and registered strobes
  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n) begin
      skip_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      err_q        <= 1'b0;
      line_drop_q  <= 1'b0;
      first_pend_q <= 1'b0;
      vld_p1       <= 1'b0;
      sof_p1       <= 1'b0;
      eol_p1       <= 1'b0;
      eof_p1       <= 1'b0;
      ferr_p1      <= 1'b0;
      o_frame_cnt  <= '0;
    end else begin
      if (state_q == S_SKIP && fe && SKIP_N != 9'd0)
        skip_cnt_q <= skip_cnt_q + 8'd1;

      if (fs_go) begin
        byte_cnt_q   <= '0;
        pix_cnt_q    <= '0;
        line_cnt_q   <= '0;
        err_q        <= 1'b0;
        line_drop_q  <= 1'b0;
        first_pend_q <= 1'b1;
      end else begin
        if (hfall_act) begin
          byte_cnt_q  <= '0;
          pix_cnt_q   <= '0;
          line_cnt_q  <= line_cnt_nx;
          line_drop_q <= 1'b0;
        end else if (beat) begin
          byte_cnt_q  <= pix_done ? '0 : byte_cnt_q + 1'b1;
          line_drop_q <= line_kill;
          if (pix_emit) pix_cnt_q <= pix_cnt_q + 1'b1;
        end
        if (err_set)  err_q        <= 1'b1;
        if (pix_emit) first_pend_q <= 1'b0;
      end

      vld_p1  <= pix_emit;
      sof_p1  <= pix_emit & first_pend_q;
      eol_p1  <= pix_emit & (pix_cnt_q == PC_EOL);
      eof_p1  <= eof_d;
      ferr_p1 <= ferr_d;
      if (cnt_inc) o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (beat) acc_q <= acc_nx;
  end

  always_ff @(posedge i_pclk or negedge rst_n) begin
    if (!rst_n)        o_data <= '0;
    else if (pix_emit) o_data <= acc_nx;
  end

  // FIFO full is honoured combinationally so a full FIFO never sees a write
  assign o_data_vld  = vld_p1 & ~i_fifo_full;
  assign o_sof       = sof_p1 & o_data_vld;
  assign o_eol       = eol_p1 & o_data_vld;
  assign o_eof       = eof_p1;
  assign o_frame_err = ferr_p1;

endmodule

// File: tb/tb_ova_capture.sv
// Directed bench for ova_capture: golden frame, table of faulty frames,
// mid-line reset and an inverted-vsync 3-byte-per-pixel instance.
module tb_ova_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_drv = '0;
  logic        href_drv = 1'b0;
  logic        blank_drv = 1'b1;
  logic        full_drv = 1'b0;
  int          sel = 0;
  int          cyc = 0;
  int          full_cyc = -100;
  logic [7:0]  byte_seq = 8'h01;

  logic        href_a, vs_a, href_b, vs_b;
  logic [15:0] o_data_a;
  logic        o_vld_a, o_sof_a, o_eol_a, o_eof_a, o_err_a;
  logic [15:0] o_cnt_a;
  logic [23:0] o_data_b;
  logic        o_vld_b, o_sof_b, o_eol_b, o_eof_b, o_err_b;
  logic [15:0] o_cnt_b;

  assign vs_a   = (sel == 0) ? blank_drv : 1'b1;
  assign href_a = (sel == 0) & href_drv;
  assign vs_b   = (sel == 1) ? ~blank_drv : 1'b0;
  assign href_b = (sel == 1) & href_drv;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ova_capture #(.DW_IN(8), .BYTES_PER_PIX(2), .H_ACT(4), .V_ACT(2),
                .SKIP_FRAMES(1), .VS_POL(1'b1)) dut_a (
    .i_pclk(clk), .rst_n(rst_n), .i_data(data_drv), .href(href_a), .vsync(vs_a),
    .i_fifo_full(full_drv), .o_data(o_data_a), .o_data_vld(o_vld_a), .o_sof(o_sof_a),
    .o_eol(o_eol_a), .o_eof(o_eof_a), .o_frame_err(o_err_a), .o_frame_cnt(o_cnt_a));

  ova_capture #(.DW_IN(8), .BYTES_PER_PIX(3), .H_ACT(2), .V_ACT(2),
                .SKIP_FRAMES(0), .VS_POL(1'b0)) dut_b (
    .i_pclk(clk), .rst_n(rst_n), .i_data(data_drv), .href(href_b), .vsync(vs_b),
    .i_fifo_full(1'b0), .o_data(o_data_b), .o_data_vld(o_vld_b), .o_sof(o_sof_b),
    .o_eol(o_eol_b), .o_eof(o_eof_b), .o_frame_err(o_err_b), .o_frame_cnt(o_cnt_b));

  typedef struct {
    logic [15:0] d;
    bit          sof;
    bit          eol;
    int          c;
  } strobe_t;

  strobe_t     sq[$];
  logic [23:0] qb[$];
  int str_tot = 0, eol_tot = 0, sof_tot = 0, eof_tot = 0, err_tot = 0;
  int eof_b = 0, err_b = 0, sof_b = 0;
  int last_cyc[$];

  always @(negedge clk) begin
    if (o_vld_a) begin
      sq.push_back('{o_data_a, o_sof_a, o_eol_a, cyc});
      str_tot++;
      if (o_eol_a) eol_tot++;
      if (o_sof_a) sof_tot++;
    end
    if (o_eof_a) eof_tot++;
    if (o_err_a) err_tot++;
    if (o_vld_b) qb.push_back(o_data_b);
    if (o_sof_b) sof_b++;
    if (o_eof_b) eof_b++;
    if (o_err_b) err_b++;
  end

  int total = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    full_drv = (cyc == full_cyc);
  endtask

  task automatic send_frame(input int nl, input int lb0, input int lb1, input int lb2,
                            input int bpp, input int full_at);
    int pix;
    int n;
    pix = 0;
    blank_drv = 1'b1; href_drv = 1'b0;
    repeat (3) tick();
    blank_drv = 1'b0;
    repeat (2) tick();
    for (int l = 0; l < nl; l++) begin
      n = (l == 0) ? lb0 : (l == 1) ? lb1 : lb2;
      for (int i = 0; i < n; i++) begin
        href_drv = 1'b1;
        data_drv = byte_seq;
        byte_seq = byte_seq + 8'd1;
        if (i % bpp == bpp - 1) begin
          last_cyc.push_back(cyc);
          if (pix == full_at) full_cyc = cyc + 2;
          pix++;
        end
        tick();
      end
      href_drv = 1'b0;
      repeat (3) tick();
    end
    blank_drv = 1'b1;
    repeat (5) tick();
  endtask

  typedef struct {
    int nl, lb0, lb1, lb2, full_at;
    int exp_str, exp_eol, exp_err, exp_cnt;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, e0, f0, r0, base;
    logic [15:0] exp_d;

    tbl[0] = '{2, 7, 8, 0, -1, 7, 1, 1, 1};
    tbl[1] = '{2, 12, 8, 0, -1, 8, 2, 1, 1};
    tbl[2] = '{2, 8, 8, 0, 2, 2, 0, 1, 1};
    tbl[3] = '{2, 8, 8, 0, -1, 8, 2, 0, 2};
    tbl[4] = '{2, 6, 8, 0, -1, 7, 1, 1, 2};
    tbl[5] = '{1, 8, 0, 0, -1, 4, 1, 1, 2};
    tbl[6] = '{3, 8, 8, 8, -1, 8, 2, 1, 2};
    tbl[7] = '{2, 8, 8, 0, -1, 8, 2, 0, 3};

    repeat (3) tick();
    check("reset_vld", {31'd0, o_vld_a}, 32'd0);
    check("reset_eof", {31'd0, o_eof_a}, 32'd0);
    check("reset_data", {16'd0, o_data_a}, 32'd0);
    check("reset_cnt", {16'd0, o_cnt_a}, 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // skipped settle frame
    s0 = str_tot; e0 = eof_tot;
    byte_seq = 8'h01;
    send_frame(2, 8, 8, 0, 2, -1);
    check("skip_strobes", str_tot - s0, 32'd0);
    check("skip_eof", eof_tot - e0, 32'd0);

    // golden frame
    s0 = str_tot; e0 = eof_tot; r0 = err_tot; base = last_cyc.size(); f0 = sq.size();
    byte_seq = 8'h01;
    send_frame(2, 8, 8, 0, 2, -1);
    check("gold_strobes", str_tot - s0, 32'd8);
    check("gold_eof", eof_tot - e0, 32'd1);
    check("gold_err", err_tot - r0, 32'd0);
    check("gold_cnt", {16'd0, o_cnt_a}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      exp_d = {8'(2 * k + 1), 8'(2 * k + 2)};
      if (f0 + k < sq.size() && base + k < last_cyc.size()) begin
        check($sformatf("gold_data%0d", k), {16'd0, sq[f0 + k].d}, {16'd0, exp_d});
        check($sformatf("gold_sof%0d", k), {31'd0, sq[f0 + k].sof}, (k == 0) ? 32'd1 : 32'd0);
        check($sformatf("gold_eol%0d", k), {31'd0, sq[f0 + k].eol},
              (k == 3 || k == 7) ? 32'd1 : 32'd0);
        check($sformatf("gold_lat%0d", k), sq[f0 + k].c - last_cyc[base + k], 32'd2);
      end else begin
        check($sformatf("gold_missing%0d", k), 32'd0, 32'd1);
      end
    end

    // table of faulty and clean frames
    for (int t = 0; t < 8; t++) begin
      s0 = str_tot; e0 = eof_tot; r0 = err_tot; f0 = eol_tot;
      send_frame(tbl[t].nl, tbl[t].lb0, tbl[t].lb1, tbl[t].lb2, 2, tbl[t].full_at);
      check($sformatf("t%0d_strobes", t), str_tot - s0, tbl[t].exp_str);
      check($sformatf("t%0d_eols", t), eol_tot - f0, tbl[t].exp_eol);
      check($sformatf("t%0d_eof", t), eof_tot - e0, 32'd1);
      check($sformatf("t%0d_err", t), err_tot - r0, tbl[t].exp_err);
      check($sformatf("t%0d_cnt", t), {16'd0, o_cnt_a}, tbl[t].exp_cnt);
    end

    // reset asserted mid-line while capturing
    blank_drv = 1'b1; href_drv = 1'b0;
    repeat (3) tick();
    blank_drv = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      href_drv = 1'b1; data_drv = 8'hA0 + 8'(i);
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", {16'd0, o_cnt_a}, 32'd0);
    check("arst_data", {16'd0, o_data_a}, 32'd0);
    check("arst_vld", {31'd0, o_vld_a}, 32'd0);
    tick();
    href_drv = 1'b0; blank_drv = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    s0 = str_tot; e0 = eof_tot;
    send_frame(2, 8, 8, 0, 2, -1);
    check("rst_skip_strobes", str_tot - s0, 32'd0);
    check("rst_skip_eof", eof_tot - e0, 32'd0);
    s0 = str_tot; e0 = eof_tot; r0 = sof_tot;
    send_frame(2, 8, 8, 0, 2, -1);
    check("rst_cap_strobes", str_tot - s0, 32'd8);
    check("rst_cap_sof", sof_tot - r0, 32'd1);
    check("rst_cap_cnt", {16'd0, o_cnt_a}, 32'd1);

    // inverted vsync, three bytes per pixel
    sel = 1;
    repeat (3) tick();
    f0 = qb.size(); e0 = eof_b; r0 = err_b;
    byte_seq = 8'h21;
    send_frame(2, 6, 6, 0, 3, -1);
    check("b_strobes", qb.size() - f0, 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (f0 + k < qb.size())
        check($sformatf("b_data%0d", k), {8'd0, qb[f0 + k]},
              {8'd0, 8'(8'h21 + 3 * k), 8'(8'h22 + 3 * k), 8'(8'h23 + 3 * k)});
      else
        check($sformatf("b_missing%0d", k), 32'd0, 32'd1);
    end
    check("b_sof", sof_b, 32'd1);
    check("b_eof", eof_b - e0, 32'd1);
    check("b_err", err_b - r0, 32'd0);
    check("b_cnt", {16'd0, o_cnt_b}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end

endmodule
